// File: rtl/vend_pkg.sv
// Types and constants shared by the vending controller and the change dispenser.
// The change code counts 0.5 units: bit 1 requests a 1.0 coin, bit 0 a 0.5 coin.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND,
        ST_P10,
        ST_W10,
        ST_P05,
        ST_W05,
        ST_DONE,
        ST_ERR
    } disp_state_e;

    localparam logic [1:0] CHG_NONE = 2'd0;
    localparam logic [1:0] CHG_05   = 2'd1;
    localparam logic [1:0] CHG_10   = 2'd2;
    localparam logic [1:0] CHG_15   = 2'd3;

    // Phase that follows 'cur' once it has finished; phases not requested
    // by the latched sell flag and change code are skipped.
    function automatic disp_state_e next_phase(
        input disp_state_e cur,
        input logic        sell,
        input logic [1:0]  chg
    );
        next_phase = ST_DONE;
        if ((cur == ST_IDLE) && sell) begin
            next_phase = ST_VEND;
        end else if (((cur == ST_IDLE) || (cur == ST_VEND)) && chg[1]) begin
            next_phase = ST_P10;
        end else if ((cur != ST_P05) && (cur != ST_W05) && chg[0]) begin
            next_phase = ST_P05;
        end
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller / hopper pads and the
// change dispenser. The master side drives requests and acks.
interface change_dispenser_if;

    logic       sell;
    logic [1:0] change;
    logic       coin10_ack;
    logic       coin05_ack;
    logic       err_clr;

    logic       vend_out;
    logic       coin10_out;
    logic       coin05_out;
    logic       busy;
    logic       done;
    logic       err;
    logic       ovf;

    modport master (
        output sell,
        output change,
        output coin10_ack,
        output coin05_ack,
        output err_clr,
        input  vend_out,
        input  coin10_out,
        input  coin05_out,
        input  busy,
        input  done,
        input  err,
        input  ovf
    );

    modport slave (
        input  sell,
        input  change,
        input  coin10_ack,
        input  coin05_ack,
        input  err_clr,
        output vend_out,
        output coin10_out,
        output coin05_out,
        output busy,
        output done,
        output err,
        output ovf
    );

endinterface

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter shared by the pulse-width and ack-timeout phases.
// It stops at zero and flags it.
module disp_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Executes one vending result: vend motor pulse, then 1.0 and 0.5 coin
// ejects, each with a hopper ack handshake and timeout.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 200,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);

    disp_state_e state_q;
    disp_state_e state_d;

    logic       sell_q;
    logic       sell_d;
    logic [1:0] chg_q;
    logic [1:0] chg_d;
    logic       ack10_q;
    logic       ack10_d;
    logic       ack05_q;
    logic       ack05_d;
    logic       ovf_q;
    logic       ovf_d;

    logic vend_q;
    logic vend_d;
    logic coin10_q;
    logic coin10_d;
    logic coin05_q;
    logic coin05_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;
    logic err_q;
    logic err_d;

    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic ev;
    logic ack10_now;
    logic ack05_now;

    disp_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign ev        = bus.sell | (bus.change != CHG_NONE);
    assign ack10_now = ack10_q | bus.coin10_ack;
    assign ack05_now = ack05_q | bus.coin05_ack;

    // Acks are remembered for the whole pulse+wait of their own coin type,
    // so an early ack lets the wait phase be skipped entirely.
    always_comb begin
        state_d  = state_q;
        sell_d   = sell_q;
        chg_d    = chg_q;
        ovf_d    = ovf_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;

        ack10_d = ((state_q == ST_P10) || (state_q == ST_W10)) && ack10_now;
        ack05_d = ((state_q == ST_P05) || (state_q == ST_W05)) && ack05_now;

        case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    sell_d  = bus.sell;
                    chg_d   = bus.change;
                    state_d = next_phase(ST_IDLE, bus.sell, bus.change);
                end
            end
            ST_VEND: begin
                if (tmr_zero) begin
                    state_d = next_phase(ST_VEND, sell_q, chg_q);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_P10: begin
                if (tmr_zero) begin
                    state_d = ack10_now ? next_phase(ST_W10, sell_q, chg_q) : ST_W10;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_W10: begin
                if (ack10_now) begin
                    state_d = next_phase(ST_W10, sell_q, chg_q);
                end else if (tmr_zero) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_P05: begin
                if (tmr_zero) begin
                    state_d = ack05_now ? ST_DONE : ST_W05;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_W05: begin
                if (ack05_now) begin
                    state_d = ST_DONE;
                end else if (tmr_zero) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (bus.err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            if ((state_d == ST_VEND) || (state_d == ST_P10) || (state_d == ST_P05)) begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(PULSE_CYC - 1);
            end else if ((state_d == ST_W10) || (state_d == ST_W05)) begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(ACK_TIMEOUT - 1);
            end
        end

        // err_clr always wins over a simultaneous dropped event
        if (bus.err_clr) begin
            ovf_d = 1'b0;
        end else if (ev && (state_q != ST_IDLE)) begin
            ovf_d = 1'b1;
        end

        vend_d   = (state_d == ST_VEND);
        coin10_d = (state_d == ST_P10);
        coin05_d = (state_d == ST_P05);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sell_q   <= 1'b0;
            chg_q    <= CHG_NONE;
            ack10_q  <= 1'b0;
            ack05_q  <= 1'b0;
            ovf_q    <= 1'b0;
            vend_q   <= 1'b0;
            coin10_q <= 1'b0;
            coin05_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sell_q   <= sell_d;
            chg_q    <= chg_d;
            ack10_q  <= ack10_d;
            ack05_q  <= ack05_d;
            ovf_q    <= ovf_d;
            vend_q   <= vend_d;
            coin10_q <= coin10_d;
            coin05_q <= coin05_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.vend_out   = vend_q;
    assign bus.coin10_out = coin10_q;
    assign bus.coin05_out = coin05_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a literal vector table, directed sequences and
// randomized transactions expanded into expected per-cycle output timelines.
module tb_change_dispenser;

    localparam int PULSE  = 4;
    localparam int ACK_TO = 200;
    localparam int HELD   = -1;
    localparam int EARLY  = -2;
    localparam int NOACK  = 100000;

    // exp = {vend, coin10, coin05, busy, done, err, ovf}
    typedef struct {
        logic       sell;
        logic [1:0] change;
        logic       a10;
        logic       a05;
        logic       clr;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    change_dispenser_if bus ();

    change_dispenser #(
        .PULSE_CYC   (PULSE),
        .ACK_TIMEOUT (ACK_TO),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   step    = 0;
    vec_t plan[$];
    vec_t basic_tbl[10];
    logic m_ovf   = 1'b0;
    int   inj     = -1;

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {bus.vend_out, bus.coin10_out, bus.coin05_out, bus.busy,
               bus.done, bus.err, bus.ovf};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s step %0d: got %b expected %b (vend c10 c05 busy done err ovf)",
                     name, step, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] c, input logic a10, a05, clr);
        bus.sell       = s;
        bus.change     = c;
        bus.coin10_ack = a10;
        bus.coin05_ack = a05;
        bus.err_clr    = clr;
    endtask

    // Each entry: inputs driven during a cycle, outputs expected in that cycle.
    task automatic applyStimulus(input string name);
        vec_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(posedge clk);
            #1;
            drive(e.sell, e.change, e.a10, e.a05, e.clr);
            @(negedge clk);
            step++;
            checkOutput(name, e.exp);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference timeline builder; the sticky ovf bit follows the event rules.
    task automatic push(input logic s, input logic [1:0] c, input logic a10, a05, clr,
                        v, c10, c05, bsy, dn, er);
        vec_t e;
        e.sell = s; e.change = c; e.a10 = a10; e.a05 = a05; e.clr = clr;
        if (bsy && (inj == 0)) e.sell = 1'b1;
        if (bsy && (inj >= 0)) inj--;
        e.exp = {v, c10, c05, bsy, dn, er, m_ovf};
        plan.push_back(e);
        if (clr) m_ovf = 1'b0;
        else if (bsy && (e.sell || (c != 2'd0))) m_ovf = 1'b1;
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            push(0, 2'd0, noise & $urandom_range(0, 1), noise & $urandom_range(0, 1), 0,
                 0, 0, 0, 0, 0, 0);
        end
    endtask

    // d: HELD = ack high whole pulse, EARLY = ack in first pulse cycle only,
    // d >= 0 = one-cycle ack d cycles after the pulse falls, >= ACK_TO = none.
    task automatic coin_phase(input logic ten, input int d, output bit ok);
        logic a;
        logic nz;
        int   wlen;
        ok = 1'b1;
        for (int i = 0; i < PULSE; i++) begin
            a = (d == HELD) || ((d == EARLY) && (i == 0));
            push(0, 2'd0, ten & a, ~ten & a, 0, 0, ten, ~ten, 1, 0, 0);
        end
        if (d >= 0) begin
            wlen = (d < ACK_TO) ? d + 1 : ACK_TO;
            for (int i = 0; i < wlen; i++) begin
                a  = (i == d);
                nz = (i < d) && ($urandom_range(0, 3) == 0);
                push(0, 2'd0, ten ? a : nz, ten ? nz : a, 0, 0, 0, 0, 1, 0, 0);
            end
            if (d >= ACK_TO) ok = 1'b0;
        end
    endtask

    task automatic txn(input logic s, input logic [1:0] c, input int d10, d05, output bit ok);
        push(s, c, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (s) begin
            for (int i = 0; i < PULSE; i++) push(0, 2'd0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        end
        ok = 1'b1;
        if (c[1]) coin_phase(1'b1, d10, ok);
        if (ok && c[0]) coin_phase(1'b0, d05, ok);
        if (ok) push(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic err_recover();
        push(0, 2'd0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        push(1, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        push(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        push(1, 2'd3, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        push(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit         ok;
        int         r;
        int         d10;
        int         d05;
        logic       s;
        logic [1:0] c;

        basic_tbl[0] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 7'b0000000};
        basic_tbl[1] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 7'b0000000};
        basic_tbl[2] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        basic_tbl[3] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001000};
        basic_tbl[4] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001000};
        basic_tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001001};
        basic_tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b1001001};
        basic_tbl[7] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0001101};
        basic_tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 7'b0000001};
        basic_tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 7'b0000000};

        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset", 7'b0000000);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) plan.push_back(basic_tbl[i]);
        applyStimulus("table");

        txn(1, 2'd3, 3, 3, ok);
        idle(2, 0);
        applyStimulus("sell_chg3");

        txn(0, 2'd1, 0, 2, ok);
        idle(1, 1);
        applyStimulus("refund");

        txn(0, 2'd3, HELD, 1, ok);
        idle(1, 0);
        applyStimulus("held_ack");

        txn(0, 2'd2, NOACK, 0, ok);
        if (!ok) err_recover();
        idle(1, 0);
        applyStimulus("timeout");

        inj = 2;
        txn(1, 2'd3, 0, EARLY, ok);
        inj = -1;
        idle(1, 0);
        push(0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        applyStimulus("overflow");

        push(0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        push(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        applyStimulus("pre_rst");
        checkOutput("mid_p10", {3'b010, 1'b1, 2'b00, m_ovf});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 7'b0000000);
        rst   = 1'b0;
        m_ovf = 1'b0;
        plan.delete();
        txn(1, 2'd0, 0, 0, ok);
        idle(1, 0);
        applyStimulus("after_rst");

        for (int t = 0; t < 40; t++) begin
            s = $urandom_range(0, 1);
            c = 2'($urandom_range(0, 3));
            if (!s && (c == 2'd0)) c = 2'd1;
            r   = $urandom_range(0, 9);
            d10 = (r == 0) ? HELD : (r == 1) ? EARLY : (r == 2) ? NOACK :
                  (r == 9) ? ACK_TO - 1 : r - 3;
            r   = $urandom_range(0, 9);
            d05 = (r == 0) ? HELD : (r == 1) ? EARLY : (r == 2) ? NOACK :
                  (r == 9) ? ACK_TO - 1 : r - 3;
            inj = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            txn(s, c, d10, d05, ok);
            inj = -1;
            if (!ok) err_recover();
            if ($urandom_range(0, 3) == 0) push(0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            idle($urandom_range(0, 2), 1);
            applyStimulus("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side companion of the vending controller: consumes the controller's per-transaction result (`sell` pulse plus 2-bit `change` code) and physically executes it.
- Fires the item-vend motor, then drives the coin hopper with pulse/ack handshakes: 1.0 coins first, then 0.5 coins.
- Sits between the vending FSM and the actuator/hopper pads.
- Reports `busy`, per-transaction `done`, and sticky error/overflow status.

Parameters:
- PULSE_CYC, 4, width in clk cycles of every actuator pulse (vend_out, coin10_out, coin05_out); legal range 1..255.
- ACK_TIMEOUT, 200, max cycles to wait for hopper ack after a coin pulse ends; legal range 1..65535.
- CNT_W, 16, width of the shared pulse/timeout counter; must hold max(PULSE_CYC, ACK_TIMEOUT).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- sell  input  1  one-cycle pulse from vending controller: an item was paid for
- change  input  2  change code in 0.5 units: 0 none, 1 = 0.5, 2 = 1.0, 3 = 1.5
- coin10_ack  input  1  hopper confirms one 1.0 coin ejected (level, sampled)
- coin05_ack  input  1  hopper confirms one 0.5 coin ejected (level, sampled)
- err_clr  input  1  one-cycle pulse: clears err/ovf and aborts ERR state
- vend_out  output  1  item motor pulse
- coin10_out  output  1  1.0-coin hopper eject pulse
- coin05_out  output  1  0.5-coin hopper eject pulse
- busy  output  1  transaction in progress (any state but IDLE)
- done  output  1  one-cycle pulse, transaction finished successfully
- err  output  1  sticky: hopper ack timeout
- ovf  output  1  sticky: new event arrived while busy (event dropped)

Behaviour:
- Reset: all outputs 0, state IDLE, latches and counter 0.
- Outputs are registered.
- Event: any cycle with `sell`=1 or `change`!=0.
- Event while IDLE at cycle N:
  - latch sell_q and chg_q;
  - state leaves IDLE at N+1, and the first actuator output rises at N+1.
- Event while not IDLE: dropped; ovf=1 from the next cycle, held until err_clr or rst.
- `sell`=0 with `change`!=0 is a refund: vend is skipped, coins are still paid.
- States:
  - IDLE.
  - VEND: vend_out=1 for PULSE_CYC cycles.
  - P10: coin10_out=1 for PULSE_CYC cycles.
  - W10: await coin10_ack.
  - P05: coin05_out=1 for PULSE_CYC cycles.
  - W05: await coin05_ack.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR.
- Sequencing:
  - Start with VEND if sell_q is set.
  - Then P10/W10 if chg_q[1].
  - Then P05/W05 if chg_q[0].
  - Then DONE. Skipped phases take zero cycles.
- Code 3 pays one 1.0 then one 0.5; code 2 pays one 1.0; code 1 pays one 0.5.
- Pulse phases: counter loads PULSE_CYC-1 on entry; the phase exits when the counter reaches 0. The output is high exactly PULSE_CYC cycles.
- Ack handling:
  - An ack sampled high during the pulse phase or the wait phase is recorded.
  - A recorded ack at pulse end skips the wait phase (zero wait cycles).
  - Otherwise the wait phase counts ACK_TIMEOUT cycles; ack seen -> next phase the following cycle.
  - Ack of the wrong coin type is ignored.
  - Ack in IDLE is ignored.
- Timeout (ACK_TIMEOUT cycles without ack): go to ERR.
  - err=1; busy stays 1; no further pulses.
  - The remaining dispensing is abandoned; done is not asserted.
- ERR exits only via err_clr (-> IDLE next cycle, err=0, ovf=0) or rst.
- err_clr outside ERR clears ovf only; it is not an event.
- Simultaneous event and err_clr in ERR: err_clr wins and the event is dropped without setting ovf.
- Async rst mid-transaction: immediate return to IDLE. All pulses drop in the same instant; no done.
- Back-to-back: an event in the cycle after DONE (state IDLE) is accepted normally.

Decomposition:
- Shared package (vend_pkg): state enum; change code constants CHG_NONE/CHG_05/CHG_10/CHG_15 (shared with the vending controller).
- One sub-module: disp_timer. Loadable down-counter (CNT_W) with load/enable/zero flag, used for both the pulse width and the timeout.

Test Plan:
- Reset defaults: PULSE_CYC=4. sell=1, change=3 at cycle 10; acks arrive 3 cycles after each coin pulse falls.
  -> vend_out high cycles 11-14; coin10_out 15-18; coin05_out after the 10-ack; done single pulse; busy low next cycle.
- change=1, sell=0 (refund) -> no vend_out; coin05_out 4 cycles; done after coin05_ack.
- coin10_ack held high from the start of the pulse -> W10 skipped; coin05_out rises the cycle after coin10_out falls.
- change=2, no ack, ACK_TIMEOUT=200 -> err=1 exactly 200 cycles after coin10_out falls; no done; busy=1.
  - Then err_clr -> next cycle busy=0, err=0.
- Second sell pulse while busy -> ovf=1, that transaction never dispensed; the first completes normally; err_clr clears ovf.
- rst asserted mid-P10 -> coin10_out and busy drop immediately; after release, a new sell=1, change=0 gives vend only, then done.
